// File: rtl/dwconv_3x3_stream.sv
// Single-channel 3x3 depthwise convolution over a raster-scanned frame, stride 1, valid window.
// Two-stage pipeline: registered tap products, then bias add, Q-format rescale and saturation.
module dwconv_3x3_stream #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 16,
    parameter int FRAC  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    input  logic [9*DW-1:0] weight,
    input  logic [DW-1:0]   bias,
    output logic            out_valid,
    output logic [DW-1:0]   sum
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int ACC_W = 2*DW + 4;

    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // ------------------------------------------------------------------
    // Raster position counters
    // ------------------------------------------------------------------
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_last;
    logic          row_last;
    logic          frame_start;
    logic          win_ready;

    assign col_last    = (col_q == CW'(IMG_W-1));
    assign row_last    = (row_q == RW'(IMG_H-1));
    assign frame_start = in_valid && (col_q == '0) && (row_q == '0);
    assign win_ready   = in_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ------------------------------------------------------------------
    // Row buffers: lb0 holds row r-2, lb1 holds row r-1 at the current column
    // ------------------------------------------------------------------
    logic signed [DW-1:0] lb0_q [IMG_W];
    logic signed [DW-1:0] lb1_q [IMG_W];
    logic signed [DW-1:0] col_in [3];

    assign col_in[0] = lb0_q[col_q];
    assign col_in[1] = lb1_q[col_q];
    assign col_in[2] = in_data;

    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb0_q[col_q] <= col_in[1];
            lb1_q[col_q] <= col_in[2];
        end
    end

    // ------------------------------------------------------------------
    // 3x3 window: row 0 oldest, column 2 newest
    // ------------------------------------------------------------------
    logic signed [DW-1:0] win_q [3][3];
    logic                 win_vld_q;

    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
                win_q[r][2] <= col_in[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_vld_q <= 1'b0;
        end else begin
            win_vld_q <= win_ready;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-tap coefficient latch and product register
    // ------------------------------------------------------------------
    // Coefficients update on the edge that accepts (0,0); the product register
    // samples on that same edge, so in-flight windows of the previous frame still
    // multiply by the old coefficients.
    logic signed [ACC_W-1:0] prod_w [9];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            logic signed [DW-1:0]   coef_q;
            logic signed [2*DW-1:0] prod_q;

            always_ff @(posedge clk) begin
                if (frame_start) begin
                    coef_q <= weight[DW*gi +: DW];
                end
                prod_q <= coef_q * win_q[gi/3][gi%3];
            end

            assign prod_w[gi] = {{(ACC_W-2*DW){prod_q[2*DW-1]}}, prod_q};
        end
    endgenerate

    logic signed [DW-1:0] bias_q;
    logic signed [DW-1:0] bias_s1_q;
    logic                 s1_vld_q;

    always_ff @(posedge clk) begin
        if (frame_start) begin
            bias_q <= bias;
        end
        bias_s1_q <= bias_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= win_vld_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate, rescale (floor), saturate
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] res_d;
    logic        [DW-1:0]    sat_d;

    always_comb begin
        acc_d = {{(ACC_W-DW){bias_s1_q[DW-1]}}, bias_s1_q} << FRAC;
        for (int k = 0; k < 9; k++) begin
            acc_d = acc_d + prod_w[k];
        end
        res_d = acc_d >>> FRAC;
        if (res_d > SAT_HI) begin
            sat_d = SAT_HI[DW-1:0];
        end else if (res_d < SAT_LO) begin
            sat_d = SAT_LO[DW-1:0];
        end else begin
            sat_d = res_d[DW-1:0];
        end
    end

    logic          out_vld_q;
    logic [DW-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            sum_q     <= '0;
        end else begin
            out_vld_q <= s1_vld_q;
            sum_q     <= s1_vld_q ? sat_d : '0;
        end
    end

    assign out_valid = out_vld_q;
    assign sum       = sum_q;

endmodule

// File: tb/tb_dwconv_3x3_stream.sv
// Directed self-checking bench for dwconv_3x3_stream at default parameters (8x8, Q8.8).
module tb_dwconv_3x3_stream;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [15:0]  in_data = '0;
    logic [143:0] weight = '0;
    logic [15:0]  bias = '0;
    logic         out_valid;
    logic [15:0]  sum;

    dwconv_3x3_stream #(.IMG_W(8), .IMG_H(8), .DW(16), .FRAC(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .weight    (weight),
        .bias      (bias),
        .out_valid (out_valid),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] out_q[$];
    int          ocyc_q[$];
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            out_q.push_back(sum);
            ocyc_q.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int acc18    = 0;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_kernel(input logic [15:0] center, input logic [15:0] other);
        for (int k = 0; k < 9; k++) begin
            weight[16*k +: 16] = (k == 4) ? center : other;
        end
    endtask

    task automatic clear_q();
        out_q.delete();
        ocyc_q.delete();
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    // mode 0: constant pixel cval, mode 1: raw ramp row*8+col
    task automatic feed_frame(input int mode, input logic [15:0] cval, input int gap_max);
        int          gap;
        logic [15:0] d;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
                d   = (mode == 1) ? 16'(r*8 + c) : cval;
                in_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b1;
                in_data  = d;
                @(posedge clk);
                #1;
                if (r*8 + c == 18) acc18 = cyc;
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (sum !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_sum: got %0d expected 0", $signed(sum));
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset done at cycle %0d", cyc);
    endtask

    task automatic test_identity();
        set_kernel(16'd256, 16'd0);
        bias = 16'd0;
        clear_q();
        feed_frame(0, 16'd256, 0);
        drain();
        n_checks++;
        if (out_q.size() != 36) begin
            n_fail++;
            $display("FAIL identity_count: got %0d expected 36", out_q.size());
        end
        for (int i = 0; i < out_q.size(); i++) begin
            $display("identity out[%0d] = %0d @cycle %0d", i, $signed(out_q[i]), ocyc_q[i]);
            n_checks++;
            if (out_q[i] !== 16'd256) begin
                n_fail++;
                $display("FAIL identity_val[%0d]: got %0d expected 256", i, $signed(out_q[i]));
            end
        end
        if (ocyc_q.size() > 0) begin
            n_checks++;
            if (ocyc_q[0] != acc18 + 2) begin
                n_fail++;
                $display("FAIL identity_latency: got cycle %0d expected %0d", ocyc_q[0], acc18 + 2);
            end
        end
        for (int i = 1; i < ocyc_q.size(); i++) begin
            n_checks++;
            if (ocyc_q[i] - ocyc_q[i-1] != ((i % 6 == 0) ? 3 : 1)) begin
                n_fail++;
                $display("FAIL identity_burst[%0d]: got spacing %0d expected %0d",
                         i, ocyc_q[i] - ocyc_q[i-1], (i % 6 == 0) ? 3 : 1);
            end
        end
    endtask

    task automatic test_bias();
        logic [15:0] bias_v [2];
        logic [15:0] exp_v  [2];
        bias_v[0] = 16'd128;  exp_v[0] = 16'd2432;
        bias_v[1] = 16'hF700; exp_v[1] = 16'd0;
        set_kernel(16'd256, 16'd256);
        for (int p = 0; p < 2; p++) begin
            bias = bias_v[p];
            clear_q();
            feed_frame(0, 16'd256, 0);
            drain();
            n_checks++;
            if (out_q.size() != 36) begin
                n_fail++;
                $display("FAIL bias%0d_count: got %0d expected 36", p, out_q.size());
            end
            for (int i = 0; i < out_q.size(); i++) begin
                $display("bias%0d out[%0d] = %0d", p, i, $signed(out_q[i]));
                n_checks++;
                if (out_q[i] !== exp_v[p]) begin
                    n_fail++;
                    $display("FAIL bias%0d_val[%0d]: got %0d expected %0d",
                             p, i, $signed(out_q[i]), $signed(exp_v[p]));
                end
            end
        end
        bias = 16'd0;
    endtask

    task automatic test_saturation();
        logic [15:0] tap_v [2];
        logic [15:0] exp_v [2];
        tap_v[0] = 16'h7FFF; exp_v[0] = 16'h7FFF;
        tap_v[1] = 16'h8000; exp_v[1] = 16'h8000;
        bias = 16'd0;
        for (int p = 0; p < 2; p++) begin
            set_kernel(tap_v[p], tap_v[p]);
            clear_q();
            feed_frame(0, 16'h7FFF, 0);
            drain();
            n_checks++;
            if (out_q.size() != 36) begin
                n_fail++;
                $display("FAIL sat%0d_count: got %0d expected 36", p, out_q.size());
            end
            for (int i = 0; i < out_q.size(); i++) begin
                $display("sat%0d out[%0d] = %0d", p, i, $signed(out_q[i]));
                n_checks++;
                if (out_q[i] !== exp_v[p]) begin
                    n_fail++;
                    $display("FAIL sat%0d_val[%0d]: got %0d expected %0d",
                             p, i, $signed(out_q[i]), $signed(exp_v[p]));
                end
            end
        end
    endtask

    task automatic test_ramp();
        logic [15:0] e;
        set_kernel(16'd256, 16'd256);
        bias = 16'd0;
        for (int p = 0; p < 2; p++) begin
            clear_q();
            feed_frame(1, 16'd0, (p == 0) ? 0 : 3);
            drain();
            n_checks++;
            if (out_q.size() != 36) begin
                n_fail++;
                $display("FAIL ramp%0d_count: got %0d expected 36", p, out_q.size());
            end
            for (int i = 0; i < out_q.size(); i++) begin
                e = 16'(9 * ((1 + i/6) * 8 + (1 + i%6)));
                $display("ramp%0d out[%0d] = %0d", p, i, $signed(out_q[i]));
                n_checks++;
                if (out_q[i] !== e) begin
                    n_fail++;
                    $display("FAIL ramp%0d_val[%0d]: got %0d expected %0d",
                             p, i, $signed(out_q[i]), e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        bias = 16'd0;
        set_kernel(16'd256, 16'd0);
        clear_q();
        feed_frame(0, 16'd256, 0);
        set_kernel(16'd512, 16'd0);
        feed_frame(0, 16'd256, 0);
        drain();
        n_checks++;
        if (out_q.size() != 72) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 72", out_q.size());
        end
        for (int i = 0; i < out_q.size(); i++) begin
            e = (i < 36) ? 16'd256 : 16'd512;
            $display("b2b out[%0d] = %0d", i, $signed(out_q[i]));
            n_checks++;
            if (out_q[i] !== e) begin
                n_fail++;
                $display("FAIL b2b_val[%0d]: got %0d expected %0d", i, $signed(out_q[i]), e);
            end
        end
        if (ocyc_q.size() >= 37) begin
            n_checks++;
            if (ocyc_q[36] - ocyc_q[35] != 19) begin
                n_fail++;
                $display("FAIL b2b_boundary_gap: got %0d expected 19", ocyc_q[36] - ocyc_q[35]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bias = 16'd0;
        set_kernel(16'd256, 16'd0);
        clear_q();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 16'd256;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (sum !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_sum: got %0d expected 0", $signed(sum));
        end
        n_checks++;
        if (out_q.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_leak: got %0d outputs expected 0", out_q.size());
        end
        clear_q();
        feed_frame(0, 16'd256, 0);
        drain();
        n_checks++;
        if (out_q.size() != 36) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d expected 36", out_q.size());
        end
        for (int i = 0; i < out_q.size(); i++) begin
            $display("midrst out[%0d] = %0d", i, $signed(out_q[i]));
            n_checks++;
            if (out_q[i] !== 16'd256) begin
                n_fail++;
                $display("FAIL midrst_val[%0d]: got %0d expected 256", i, $signed(out_q[i]));
            end
        end
        if (ocyc_q.size() > 0) begin
            n_checks++;
            if (ocyc_q[0] != acc18 + 2) begin
                n_fail++;
                $display("FAIL midrst_latency: got cycle %0d expected %0d", ocyc_q[0], acc18 + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_bias();
        test_saturation();
        test_ramp();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
